// File: rtl/dpram_client_arbiter_pkg.sv
// Shared types and helpers for the two-client dual-port RAM arbiter.
package dpram_client_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  typedef logic client_id_t;

  localparam client_id_t CLIENT0 = 1'b0;
  localparam client_id_t CLIENT1 = 1'b1;

  // After reset client 1 counts as the last winner, so client 0 takes the first tie.
  localparam client_id_t RESET_LAST_GRANT = CLIENT1;

  // Round-robin pick between two requesters: a lone requester wins outright,
  // a tie goes to whoever did not win last time.
  function automatic client_id_t rr_pick(input logic req0, input logic req1,
                                         input client_id_t last);
    client_id_t pick;
    if (req0 && req1) pick = ~last;
    else if (req1)    pick = CLIENT1;
    else              pick = CLIENT0;
    return pick;
  endfunction

endpackage

// File: rtl/dpram_client_arbiter_if.sv
// Client handshake and RAM port bundle for dpram_client_arbiter.
// master: the arbiter (drives acks, read data and the RAM port).
// slave:  the clients and the RAM (drive requests and ram_q).
interface dpram_client_arbiter_if #(
  parameter int widthad_a = 8,
  parameter int width_a   = 8
);

  logic                 c0_req;
  logic                 c0_we;
  logic [widthad_a-1:0] c0_addr;
  logic [width_a-1:0]   c0_wdata;
  logic                 c0_ack;
  logic                 c0_rvalid;
  logic [width_a-1:0]   c0_rdata;

  logic                 c1_req;
  logic                 c1_we;
  logic [widthad_a-1:0] c1_addr;
  logic [width_a-1:0]   c1_wdata;
  logic                 c1_ack;
  logic                 c1_rvalid;
  logic [width_a-1:0]   c1_rdata;

  logic [widthad_a-1:0] ram_address;
  logic [width_a-1:0]   ram_data;
  logic                 ram_wren;
  logic                 ram_rden;
  logic [width_a-1:0]   ram_q;

  modport master (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    input  ram_q,
    output c0_ack, c0_rvalid, c0_rdata,
    output c1_ack, c1_rvalid, c1_rdata,
    output ram_address, ram_data, ram_wren, ram_rden
  );

  modport slave (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    output ram_q,
    input  c0_ack, c0_rvalid, c0_rdata,
    input  c1_ack, c1_rvalid, c1_rdata,
    input  ram_address, ram_data, ram_wren, ram_rden
  );

endinterface

// File: rtl/dpram_client_arbiter.sv
// Round-robin arbiter putting two req/ack clients onto one RAM port with a
// one-cycle registered read latency. Every access goes IDLE -> ISSUE
// (strobe + ack) and, for reads, RDWAIT before the data is handed back.
module dpram_client_arbiter
  import dpram_client_arbiter_pkg::*;
#(
  parameter int widthad_a = 8,
  parameter int width_a   = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  dpram_client_arbiter_if.master bus
);

  state_t               r_state, w_state_nxt;
  client_id_t           r_last_grant, w_last_grant_nxt;
  client_id_t           r_gnt, w_gnt_nxt;
  client_id_t           w_pick;
  logic                 w_any_req;

  logic                 r_we, w_we_nxt;
  logic [widthad_a-1:0] r_addr, w_addr_nxt;
  logic [width_a-1:0]   r_wdata, w_wdata_nxt;

  logic                 r_wren, w_wren_nxt;
  logic                 r_rden, w_rden_nxt;
  logic                 r_ack0, w_ack0_nxt;
  logic                 r_ack1, w_ack1_nxt;
  logic                 r_rvalid0, w_rvalid0_nxt;
  logic                 r_rvalid1, w_rvalid1_nxt;
  logic [width_a-1:0]   r_rdata0, w_rdata0_nxt;
  logic [width_a-1:0]   r_rdata1, w_rdata1_nxt;

  // Next-state and next-output decode; strobes, acks and rvalid default low
  // so each is a single-cycle pulse out of the registers below.
  always_comb begin
    w_any_req        = bus.c0_req | bus.c1_req;
    w_pick           = rr_pick(bus.c0_req, bus.c1_req, r_last_grant);

    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_wren_nxt       = 1'b0;
    w_rden_nxt       = 1'b0;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_rvalid0_nxt    = 1'b0;
    w_rvalid1_nxt    = 1'b0;
    w_rdata0_nxt     = r_rdata0;
    w_rdata1_nxt     = r_rdata1;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt      = ISSUE;
          w_gnt_nxt        = w_pick;
          w_last_grant_nxt = w_pick;
          if (w_pick == CLIENT0) begin
            w_we_nxt    = bus.c0_we;
            w_addr_nxt  = bus.c0_addr;
            w_wdata_nxt = bus.c0_wdata;
            w_ack0_nxt  = 1'b1;
          end else begin
            w_we_nxt    = bus.c1_we;
            w_addr_nxt  = bus.c1_addr;
            w_wdata_nxt = bus.c1_wdata;
            w_ack1_nxt  = 1'b1;
          end
          w_wren_nxt = w_we_nxt;
          w_rden_nxt = ~w_we_nxt;
        end
      end
      ISSUE: begin
        w_state_nxt = r_we ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // ram_q carries the read issued last cycle; route it to its owner only.
        w_state_nxt = IDLE;
        if (r_gnt == CLIENT0) begin
          w_rdata0_nxt  = bus.ram_q;
          w_rvalid0_nxt = 1'b1;
        end else begin
          w_rdata1_nxt  = bus.ram_q;
          w_rvalid1_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and pulse registers; reset drops any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= RESET_LAST_GRANT;
      r_gnt        <= CLIENT0;
      r_wren       <= 1'b0;
      r_rden       <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      r_wren       <= w_wren_nxt;
      r_rden       <= w_rden_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_rvalid0    <= w_rvalid0_nxt;
      r_rvalid1    <= w_rvalid1_nxt;
    end
  end

  // Latched request fields and returned read data; all clear to zero on reset
  // and otherwise hold until the next grant or the owner's next read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  assign bus.ram_address = r_addr;
  assign bus.ram_data    = r_wdata;
  assign bus.ram_wren    = r_wren;
  assign bus.ram_rden    = r_rden;
  assign bus.c0_ack      = r_ack0;
  assign bus.c1_ack      = r_ack1;
  assign bus.c0_rvalid   = r_rvalid0;
  assign bus.c1_rvalid   = r_rvalid1;
  assign bus.c0_rdata    = r_rdata0;
  assign bus.c1_rdata    = r_rdata1;

endmodule

// File: tb/tb_dpram_client_arbiter.sv
// Bench for dpram_client_arbiter: directed vector table, reset corner cases,
// and randomized two-client traffic against a transaction-level model.
module tb_dpram_client_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dpram_client_arbiter_if #(.widthad_a(AW), .width_a(DW)) bus ();

  dpram_client_arbiter #(.widthad_a(AW), .width_a(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM port model: registered read data, one cycle after rden.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_q_r;
  always @(posedge clock) begin
    if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data;
    if (bus.ram_rden) ram_q_r <= ram_mem[bus.ram_address];
  end
  assign bus.ram_q = ram_q_r;

  // Reference memory: what every completed write says the RAM holds.
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int id, input logic req, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (id == 0) begin
      bus.c0_req = req; bus.c0_we = we; bus.c0_addr = a; bus.c0_wdata = d;
    end else begin
      bus.c1_req = req; bus.c1_we = we; bus.c1_addr = a; bus.c1_wdata = d;
    end
  endtask

  function automatic logic ack_of(input int id);
    return (id == 0) ? bus.c0_ack : bus.c1_ack;
  endfunction
  function automatic logic rv_of(input int id);
    return (id == 0) ? bus.c0_rvalid : bus.c1_rvalid;
  endfunction
  function automatic logic [7:0] rdata_of(input int id);
    return (id == 0) ? bus.c0_rdata : bus.c1_rdata;
  endfunction

  task automatic apply_reset();
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- transaction-level model / monitor ----------------
  // Rules: an idle arbiter grants at an edge if anyone requested; a tie goes
  // to the client that did not win last; a write keeps the port for 2 cycles,
  // a read for 3 with rvalid two cycles after its ack.
  bit           mon_en = 1'b0;
  int           grant_log [$];
  int           m_k, m_free, m_rv_step, m_rv_cli, m_w;
  logic         m_last;
  logic [7:0]   m_rv_data, m_addr, m_data;
  logic [7:0]   m_rd [2];
  logic         m_preq [2], m_pwe [2];
  logic [7:0]   m_pa [2], m_pd [2];
  logic         e_ack [2], e_rv [2];
  logic         e_wr, e_rd;

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!mon_en) begin
        m_k = 0; m_free = 0; m_rv_step = -1; m_rv_cli = 0; m_last = 1'b1;
        m_addr = '0; m_data = '0; m_rd[0] = '0; m_rd[1] = '0; m_rv_data = '0;
        m_preq[0] = 1'b0; m_preq[1] = 1'b0;
        m_pwe[0] = 1'b0; m_pwe[1] = 1'b0;
        m_pa[0] = '0; m_pa[1] = '0; m_pd[0] = '0; m_pd[1] = '0;
      end else begin
        e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_rv[0] = 1'b0; e_rv[1] = 1'b0;
        e_wr = 1'b0; e_rd = 1'b0;
        if (m_k == m_rv_step) begin
          e_rv[m_rv_cli] = 1'b1;
          m_rd[m_rv_cli] = m_rv_data;
        end
        if (m_k >= m_free && (m_preq[0] || m_preq[1])) begin
          if (m_preq[0] && m_preq[1]) m_w = m_last ? 0 : 1;
          else                        m_w = m_preq[1] ? 1 : 0;
          m_last = (m_w == 1);
          grant_log.push_back(m_w);
          e_ack[m_w] = 1'b1;
          m_addr = m_pa[m_w];
          m_data = m_pd[m_w];
          if (m_pwe[m_w]) begin
            e_wr = 1'b1;
            ref_mem[m_addr] = m_data;
            m_free = m_k + 2;
          end else begin
            e_rd = 1'b1;
            m_rv_step = m_k + 2;
            m_rv_cli  = m_w;
            m_rv_data = ref_mem[m_addr];
            m_free    = m_k + 3;
          end
        end
        chk("mon_c0_ack",    32'(bus.c0_ack),      32'(e_ack[0]));
        chk("mon_c1_ack",    32'(bus.c1_ack),      32'(e_ack[1]));
        chk("mon_wren",      32'(bus.ram_wren),    32'(e_wr));
        chk("mon_rden",      32'(bus.ram_rden),    32'(e_rd));
        chk("mon_address",   32'(bus.ram_address), 32'(m_addr));
        chk("mon_data",      32'(bus.ram_data),    32'(m_data));
        chk("mon_c0_rvalid", 32'(bus.c0_rvalid),   32'(e_rv[0]));
        chk("mon_c1_rvalid", 32'(bus.c1_rvalid),   32'(e_rv[1]));
        chk("mon_c0_rdata",  32'(bus.c0_rdata),    32'(m_rd[0]));
        chk("mon_c1_rdata",  32'(bus.c1_rdata),    32'(m_rd[1]));
        m_preq[0] = bus.c0_req; m_pwe[0] = bus.c0_we; m_pa[0] = bus.c0_addr; m_pd[0] = bus.c0_wdata;
        m_preq[1] = bus.c1_req; m_pwe[1] = bus.c1_we; m_pa[1] = bus.c1_addr; m_pd[1] = bus.c1_wdata;
        m_k++;
      end
    end
  end

  // One client: n requests, each held until ack, then a 0..max_gap idle gap.
  task automatic client_run(input int id, input int n, input int max_gap,
                            input bit rnd, input logic [7:0] fixed_addr);
    for (int t = 0; t < n; t++) begin
      logic       we;
      logic [7:0] a, d;
      int         waited, gap;
      we = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = rnd ? 8'($urandom_range(0, 7)) : fixed_addr;
      d  = 8'($urandom);
      drive(id, 1'b1, we, a, d);
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!ack_of(id) && waited < 40);
      chk($sformatf("ack_timeout_c%0d", id), 32'(ack_of(id)), 32'd1);
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (gap > 0 || t == n - 1) drive(id, 1'b0, we, a, d);
      repeat (gap) @(negedge clock);
    end
    drive(id, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic run_monitored(input int n, input int max_gap, input bit rnd,
                               input logic [7:0] a0, input logic [7:0] a1);
    apply_reset();
    grant_log.delete();
    mon_en = 1'b1;
    fork
      client_run(0, n, max_gap, rnd, a0);
      client_run(1, n, max_gap, rnd, a1);
    join
    repeat (4) @(negedge clock);
    mon_en = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         cli;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic do_txn(input vec_t v);
    int         o;
    logic [7:0] other_rd;
    o = 1 - v.cli;
    other_rd = rdata_of(o);
    drive(v.cli, 1'b1, v.we, v.addr, v.wdata);
    @(negedge clock);
    chk("ack",       32'(ack_of(v.cli)),   32'd1);
    chk("other_ack", 32'(ack_of(o)),       32'd0);
    chk("wren",      32'(bus.ram_wren),    32'(v.we));
    chk("rden",      32'(bus.ram_rden),    32'(!v.we));
    chk("address",   32'(bus.ram_address), 32'(v.addr));
    chk("data",      32'(bus.ram_data),    32'(v.wdata));
    drive(v.cli, 1'b0, v.we, v.addr, v.wdata);
    @(negedge clock);
    chk("ack_pulse",  32'(ack_of(v.cli)), 32'd0);
    chk("strobe_off", 32'({bus.ram_wren, bus.ram_rden}), 32'd0);
    if (v.we) begin
      ref_mem[v.addr] = v.wdata;
    end else begin
      chk("rv_early", 32'(rv_of(v.cli)), 32'd0);
      @(negedge clock);
      chk("rvalid",      32'(rv_of(v.cli)),    32'd1);
      chk("rdata",       32'(rdata_of(v.cli)), 32'(v.exp));
      chk("other_rv",    32'(rv_of(o)),        32'd0);
      chk("other_rdata", 32'(rdata_of(o)),     32'(other_rd));
      @(negedge clock);
      chk("rv_pulse",   32'(rv_of(v.cli)),    32'd0);
      chk("rdata_hold", 32'(rdata_of(v.cli)), 32'(v.exp));
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] <= 8'(i) ^ 8'h3C;
      ref_mem[i]  = 8'(i) ^ 8'h3C;
    end
    vecs[0] = '{cli: 0, we: 1'b1, addr: 8'h12, wdata: 8'h5A, exp: 8'h00};
    vecs[1] = '{cli: 0, we: 1'b0, addr: 8'h12, wdata: 8'h00, exp: 8'h5A};
    vecs[2] = '{cli: 1, we: 1'b1, addr: 8'h34, wdata: 8'hC3, exp: 8'h00};
    vecs[3] = '{cli: 1, we: 1'b0, addr: 8'h34, wdata: 8'h11, exp: 8'hC3};
    vecs[4] = '{cli: 0, we: 1'b0, addr: 8'h01, wdata: 8'h22, exp: 8'h3D};
    vecs[5] = '{cli: 1, we: 1'b1, addr: 8'h00, wdata: 8'hFF, exp: 8'h00};
    vecs[6] = '{cli: 0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp: 8'hC3};
    vecs[7] = '{cli: 1, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp: 8'hFF};

    // Reset state: every output zero while reset_n is low.
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_pulses", 32'({bus.c0_ack, bus.c1_ack, bus.c0_rvalid, bus.c1_rvalid,
                           bus.ram_wren, bus.ram_rden}), 32'd0);
    chk("rst_ram_addr_data", 32'({bus.ram_address, bus.ram_data}), 32'd0);
    chk("rst_rdata", 32'({bus.c0_rdata, bus.c1_rdata}), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_quiet", 32'({bus.ram_wren, bus.ram_rden, bus.c0_ack, bus.c1_ack}), 32'd0);
    end

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Simultaneous reads straight out of reset: client 0 first, then client 1.
    run_monitored(1, 0, 1'b0, 8'h01, 8'h02);
    chk("tie_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("tie_first",  32'(grant_log[0]), 32'd0);
      chk("tie_second", 32'(grant_log[1]), 32'd1);
    end

    // Both clients hold req continuously: grants must alternate 0,1,0,1...
    run_monitored(8, 0, 1'b0, 8'h12, 8'h34);
    chk("alt_count", 32'(grant_log.size()), 32'd16);
    foreach (grant_log[i]) chk($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Randomized mixed traffic with idle gaps.
    run_monitored(40, 3, 1'b1, 8'h00, 8'h00);
    chk("rand_count", 32'(grant_log.size()), 32'd80);

    // Reset asserted during RDWAIT: no rvalid afterwards, rdata cleared.
    apply_reset();
    v = '{cli: 0, we: 1'b0, addr: 8'h12, wdata: 8'h00, exp: ref_mem[8'h12]};
    do_txn(v);
    drive(0, 1'b1, 1'b0, 8'h34, 8'h00);
    @(negedge clock);
    chk("rst_mid_ack", 32'(bus.c0_ack), 32'd1);
    drive(0, 1'b0, 1'b0, 8'h34, 8'h00);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rdata",  32'(bus.c0_rdata),  32'd0);
    chk("rst_mid_rvalid", 32'(bus.c0_rvalid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_mid_quiet", 32'({bus.c0_rvalid, bus.c1_rvalid, bus.c0_ack, bus.c1_ack,
                                bus.ram_wren, bus.ram_rden}), 32'd0);
    end
    v = '{cli: 1, we: 1'b1, addr: 8'h40, wdata: 8'h77, exp: 8'h00};
    do_txn(v);
    v = '{cli: 1, we: 1'b0, addr: 8'h40, wdata: 8'h00, exp: 8'h77};
    do_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
